deu_gpr_wb_arb: RTL and testbench

//  Writeback arbiter feeding the 3 GPR write ports (we0..2/waddr0..2/wd0..2) of the GPR file.

---
 rtl/deu_gpr_wb_arb.sv | 199 +++++++++++++++++++
 tb/tb_deu_gpr_wb_arb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deu_gpr_wb_arb.sv
// Writeback arbiter for the three GPR write ports.
// Each execution source feeds a 2-entry in-order FIFO. Every cycle the FIFO
// heads are scanned in rotating-priority order and up to three writes are
// granted to the registered write ports. Heads that target r0 are dropped
// without using a port. A per-register pending mask is published for decode
// hazard checks.
module deu_gpr_wb_arb #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC-1:0]          src_valid,
    output logic [N_SRC-1:0]          src_ready,
    input  logic [N_SRC*ADDR_W-1:0]   src_waddr,
    input  logic [N_SRC*DATA_W-1:0]   src_wd,
    output logic                      we0,
    output logic                      we1,
    output logic                      we2,
    output logic [ADDR_W-1:0]         waddr0,
    output logic [ADDR_W-1:0]         waddr1,
    output logic [ADDR_W-1:0]         waddr2,
    output logic [DATA_W-1:0]         wd0,
    output logic [DATA_W-1:0]         wd1,
    output logic [DATA_W-1:0]         wd2,
    output logic [31:0]               pend_mask
);

    localparam int N_PORT = 3;
    localparam int PW     = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // Per-source FIFO: slot 0 is always the head, slot 1 the younger entry.
    logic [ADDR_W-1:0] q_addr [N_SRC][2];
    logic [DATA_W-1:0] q_data [N_SRC][2];
    logic [1:0]        q_cnt  [N_SRC];

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     rr_next;

    logic [N_SRC-1:0]  push;
    logic [N_SRC-1:0]  pop;

    // Grants produced by this cycle's arbitration, indexed by port.
    logic [N_PORT-1:0] g_vld;
    logic [ADDR_W-1:0] g_addr [N_PORT];
    logic [DATA_W-1:0] g_data [N_PORT];

    // Registered write ports.
    logic [N_PORT-1:0] p_we;
    logic [ADDR_W-1:0] p_addr [N_PORT];
    logic [DATA_W-1:0] p_data [N_PORT];

    // Ready depends only on the registered fill level, never on src_valid.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_ready[i] = (q_cnt[i] != 2'd2) && !rst;
            push[i]      = src_valid[i] && src_ready[i];
        end
    end

    // Rotating-priority scan of FIFO heads: drop r0 writes, grant up to three
    // distinct addresses, and advance the pointer past the last grant.
    always_comb begin : arb_comb
        int  n_used;
        int  last_src;
        int  idx;
        logic conflict;
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        pop      = '0;
        g_vld    = '0;
        n_used   = 0;
        last_src = 0;
        conflict = 1'b0;
        idx      = 0;
        for (int p = 0; p < N_PORT; p++) begin
            g_addr[p] = '0;
            g_data[p] = '0;
        end
        for (int k = 0; k < N_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % N_SRC;
            if (q_cnt[idx] != 2'd0) begin
                if (q_addr[idx][0] == '0) begin
                    pop[idx] = 1'b1;
                end else if (n_used < N_PORT) begin
                    conflict = 1'b0;
                    for (int p = 0; p < N_PORT; p++) begin
                        if (p < n_used && g_addr[p] == q_addr[idx][0]) begin
                            conflict = 1'b1;
                        end
                    end
                    if (!conflict) begin
                        g_vld[n_used]  = 1'b1;
                        g_addr[n_used] = q_addr[idx][0];
                        g_data[n_used] = q_data[idx][0];
                        pop[idx]       = 1'b1;
                        last_src       = idx;
                        n_used         = n_used + 1;
                    end
                end
            end
        end
        rr_next = (n_used != 0) ? PW'((last_src + 1) % N_SRC) : rr_ptr;
    end

    // FIFO fill levels: push and pop may coincide, leaving the count unchanged.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples the pre-edge values of its inputs.
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                q_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                q_cnt[i] <= q_cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
        end
    end

    // FIFO storage: shift the younger entry to the head on pop, append on push.
    // NOTE: the storage array has no reset; the fill count alone decides
    // which slots hold live data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (pop[i]) begin
                if (q_cnt[i] == 2'd2) begin
                    q_addr[i][0] <= q_addr[i][1];
                    q_data[i][0] <= q_data[i][1];
                    if (push[i]) begin
                        q_addr[i][1] <= src_waddr[i*ADDR_W +: ADDR_W];
                        q_data[i][1] <= src_wd[i*DATA_W +: DATA_W];
                    end
                end else if (push[i]) begin
                    q_addr[i][0] <= src_waddr[i*ADDR_W +: ADDR_W];
                    q_data[i][0] <= src_wd[i*DATA_W +: DATA_W];
                end
            end else if (push[i]) begin
                if (q_cnt[i] == 2'd0) begin
                    q_addr[i][0] <= src_waddr[i*ADDR_W +: ADDR_W];
                    q_data[i][0] <= src_wd[i*DATA_W +: DATA_W];
                end else begin
                    q_addr[i][1] <= src_waddr[i*ADDR_W +: ADDR_W];
                    q_data[i][1] <= src_wd[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Write ports reload every cycle; ungranted ports carry we=0 and zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            p_we   <= '0;
            for (int p = 0; p < N_PORT; p++) begin
                p_addr[p] <= '0;
                p_data[p] <= '0;
            end
        end else begin
            rr_ptr <= rr_next;
            p_we   <= g_vld;
            for (int p = 0; p < N_PORT; p++) begin
                p_addr[p] <= g_addr[p];
                p_data[p] <= g_data[p];
            end
        end
    end

    // Pending mask: any live FIFO entry or active write port targeting r.
    always_comb begin
        pend_mask = '0;
        for (int r = 1; r < 32; r++) begin
            for (int i = 0; i < N_SRC; i++) begin
                for (int e = 0; e < 2; e++) begin
                    if (int'(q_cnt[i]) > e && int'(q_addr[i][e]) == r) begin
                        pend_mask[r] = 1'b1;
                    end
                end
            end
            for (int p = 0; p < N_PORT; p++) begin
                if (p_we[p] && int'(p_addr[p]) == r) begin
                    pend_mask[r] = 1'b1;
                end
            end
        end
    end

    assign we0    = p_we[0];
    assign we1    = p_we[1];
    assign we2    = p_we[2];
    assign waddr0 = p_addr[0];
    assign waddr1 = p_addr[1];
    assign waddr2 = p_addr[2];
    assign wd0    = p_data[0];
    assign wd1    = p_data[1];
    assign wd2    = p_data[2];

endmodule

// File: tb/tb_deu_gpr_wb_arb.sv
// Scoreboard bench for the GPR writeback arbiter: directed cases queue their
// expected port writes; a negedge monitor pops and compares every write seen.
// A bulk phase tracks accepted writes by unique data for exactly-once delivery.
module tb_deu_gpr_wb_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*AW-1:0] src_waddr;
    logic [N*DW-1:0] src_wd;
    logic we0, we1, we2;
    logic [AW-1:0] waddr0, waddr1, waddr2;
    logic [DW-1:0] wd0, wd1, wd2;
    logic [31:0]   pend_mask;

    always #5 clk = ~clk;

    deu_gpr_wb_arb #(.N_SRC(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_waddr(src_waddr), .src_wd(src_wd),
        .we0(we0), .we1(we1), .we2(we2),
        .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
        .wd0(wd0), .wd1(wd1), .wd2(wd2),
        .pend_mask(pend_mask)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t           exp_q[$];
    bit             bulk = 1'b0;
    logic [AW-1:0]  bulk_map [logic [DW-1:0]];
    int             last_seq [N];
    int             seq [N];
    int             out_cnt   = 0;
    int             full3_cnt = 0;
    int             acc_cnt   = 0;
    bit             drop_seen = 1'b0;

    wire [2:0]    we_a = {we2, we1, we0};
    wire [AW-1:0] wa_a [3] = '{waddr0, waddr1, waddr2};
    wire [DW-1:0] wd_a [3] = '{wd0, wd1, wd2};

    // Monitor: every asserted write port is checked against the expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (we_a == 3'b111) full3_cnt++;
            for (int a = 0; a < 3; a++)
                for (int b = a + 1; b < 3; b++)
                    if (we_a[a] && we_a[b]) check("dup_addr", 64'(wa_a[a] == wa_a[b]), 64'd0);
            for (int p = 0; p < 3; p++) begin
                if (we_a[p]) begin
                    out_cnt++;
                    if (bulk) begin
                        check("bulk_known", 64'(bulk_map.exists(wd_a[p])), 64'd1);
                        if (bulk_map.exists(wd_a[p])) begin
                            int s;
                            int q;
                            s = int'(wd_a[p][31:24]);
                            q = int'(wd_a[p][23:0]);
                            check("bulk_addr", 64'(wa_a[p]), 64'(bulk_map[wd_a[p]]));
                            if (s < N) begin
                                check("bulk_order", 64'(q > last_seq[s]), 64'd1);
                                last_seq[s] = q;
                            end
                            bulk_map.delete(wd_a[p]);
                        end
                    end else begin
                        check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
                        if (exp_q.size() > 0) begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("sb_port", 64'(p), 64'(e.port));
                            check("sb_addr", 64'(wa_a[p]), 64'(e.addr));
                            check("sb_data", 64'(wd_a[p]), 64'(e.data));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_valid[i]           = v;
        src_waddr[i*AW +: AW]  = a;
        src_wd[i*DW +: DW]     = d;
    endtask

    task automatic exp_push(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.port = port;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = '0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Offer a fresh write on source i: unique data {src, seq}.
    task automatic offer(input int i, input int c, input bit fixed);
        logic [AW-1:0] a;
        a = fixed ? AW'(12) : AW'(((4 * c + i) % 31) + 1);
        set_src(i, 1'b1, a, {8'(i), 24'(seq[i])});
        seq[i]++;
    endtask

    // Every source stays valid each cycle; accepted writes go into the map.
    task automatic run_bulk(input int cycles, input bit fixed);
        bit acc [N];
        for (int i = 0; i < N; i++) offer(i, 0, fixed);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                acc[i] = src_valid[i] && src_ready[i];
                if (acc[i]) begin
                    bulk_map[src_wd[i*DW +: DW]] = src_waddr[i*AW +: AW];
                    acc_cnt++;
                end
                if (src_valid[i] && !src_ready[i]) drop_seen = 1'b1;
            end
            tick();
            for (int i = 0; i < N; i++)
                if (acc[i]) offer(i, c + 1, fixed);
        end
        src_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        src_valid = '0;
        src_waddr = '0;
        src_wd    = '0;
        for (int i = 0; i < N; i++) begin
            seq[i]      = 0;
            last_seq[i] = -1;
        end

        // Reset state.
        tick();
        check("rst_ready", 64'(src_ready), 64'h0);
        check("rst_we", 64'(we_a), 64'h0);
        check("rst_waddr", 64'({waddr2, waddr1, waddr0}), 64'h0);
        check("rst_wd0", 64'(wd0), 64'h0);
        check("rst_pend", 64'(pend_mask), 64'h0);
        rst = 1'b0;
        #1;
        check("rel_ready", 64'(src_ready), 64'hF);

        // 1: single write, latency and pending mask.
        exp_push(0, 5'd5, 32'hDEAD_BEEF);
        set_src(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        set_src(0, 1'b0, '0, '0);
        check("t1_n1_we", 64'(we_a), 64'h0);
        check("t1_n1_pend", 64'(pend_mask), 64'h20);
        tick();
        check("t1_n2_we", 64'(we_a), 64'h1);
        check("t1_n2_waddr0", 64'(waddr0), 64'd5);
        check("t1_n2_wd0", 64'(wd0), 64'hDEAD_BEEF);
        check("t1_n2_pend", 64'(pend_mask), 64'h20);
        tick();
        check("t1_n3_we", 64'(we_a), 64'h0);
        check("t1_n3_pend", 64'(pend_mask), 64'h0);
        check("t1_drained", 64'(exp_q.size()), 64'd0);

        // 2: four sources at once, three ports, then the fourth.
        do_reset();
        for (int i = 0; i < N; i++) begin
            exp_push(i % 3, AW'(i + 1), 32'h100 + i);
            set_src(i, 1'b1, AW'(i + 1), 32'h100 + i);
        end
        tick();
        src_valid = '0;
        tick();
        check("t2_n2_we", 64'(we_a), 64'h7);
        check("t2_n2_addrs", 64'({waddr2, waddr1, waddr0}), 64'({5'd3, 5'd2, 5'd1}));
        tick();
        check("t2_n3_we", 64'(we_a), 64'h1);
        check("t2_n3_waddr0", 64'(waddr0), 64'd4);
        // Pointer is back at 0: src0 must win over src3.
        exp_push(0, 5'd21, 32'h2100);
        exp_push(1, 5'd20, 32'h2000);
        set_src(0, 1'b1, 5'd21, 32'h2100);
        set_src(3, 1'b1, 5'd20, 32'h2000);
        tick();
        src_valid = '0;
        tick();
        check("t2_rr_we", 64'(we_a), 64'h3);
        tick();
        check("t2_drained", 64'(exp_q.size()), 64'd0);

        // 3: same-address conflict serialises the two writes.
        do_reset();
        exp_push(0, 5'd7, 32'h11);
        exp_push(0, 5'd7, 32'h22);
        set_src(1, 1'b1, 5'd7, 32'h11);
        set_src(2, 1'b1, 5'd7, 32'h22);
        tick();
        src_valid = '0;
        check("t3_n1_pend", 64'(pend_mask), 64'h80);
        tick();
        check("t3_n2_we", 64'(we_a), 64'h1);
        check("t3_n2_wd0", 64'(wd0), 64'h11);
        tick();
        check("t3_n3_we", 64'(we_a), 64'h1);
        check("t3_n3_wd0", 64'(wd0), 64'h22);
        check("t3_n3_pend", 64'(pend_mask), 64'h80);
        tick();
        check("t3_n4_we", 64'(we_a), 64'h0);
        check("t3_n4_pend", 64'(pend_mask), 64'h0);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // 4: r0 write is consumed silently and leaves the pointer alone.
        do_reset();
        set_src(0, 1'b1, 5'd0, 32'h5);
        check("t4_ready", 64'(src_ready[0]), 64'd1);
        tick();
        src_valid = '0;
        check("t4_n1_pend", 64'(pend_mask), 64'h0);
        tick();
        check("t4_n2_we", 64'(we_a), 64'h0);
        check("t4_n2_pend", 64'(pend_mask), 64'h0);
        check("t4_n2_ready", 64'(src_ready), 64'hF);
        exp_push(0, 5'd10, 32'h1010);
        exp_push(1, 5'd9, 32'h99);
        set_src(0, 1'b1, 5'd10, 32'h1010);
        set_src(3, 1'b1, 5'd9, 32'h99);
        tick();
        src_valid = '0;
        tick();
        tick();
        check("t4_drained", 64'(exp_q.size()), 64'd0);

        // 5: sustained traffic from all sources.
        do_reset();
        bulk      = 1'b1;
        acc_cnt   = 0;
        out_cnt   = 0;
        full3_cnt = 0;
        drop_seen = 1'b0;
        run_bulk(100, 1'b0);
        check("t5_throughput", 64'(full3_cnt >= 60), 64'd1);
        check("t5_ready_drop", 64'(drop_seen), 64'd1);
        for (int i = 0; i < 10; i++) tick();
        check("t5_all_out", 64'(bulk_map.size()), 64'd0);
        check("t5_once", 64'(out_cnt), 64'(acc_cnt));

        // 6: reset with full FIFOs discards everything queued.
        drop_seen = 1'b0;
        run_bulk(6, 1'b1);
        check("t6_filled", 64'(drop_seen), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 64'(src_ready), 64'h0);
        tick();
        check("t6_we", 64'(we_a), 64'h0);
        check("t6_pend", 64'(pend_mask), 64'h0);
        bulk_map.delete();
        bulk = 1'b0;
        rst  = 1'b0;
        #1;
        check("t6_rel_ready", 64'(src_ready), 64'hF);
        out_cnt = 0;
        for (int i = 0; i < 10; i++) tick();
        check("t6_no_stale", 64'(out_cnt), 64'd0);
        check("t6_pend_end", 64'(pend_mask), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
